// File: rtl/bat_loader_pkg.sv
// -----------------------------------------------------------------------------
// bat_loader_pkg
// Shared definitions for the halt-mode program loader and the CPU top that
// will instantiate it: loader state encoding and RAM direction constants.
// Optional build macro: BAT_LOADER_VERIFY_READBACK_EN adds the VERIFY state.
// -----------------------------------------------------------------------------
package bat_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCEPT,
    ST_WRITE,
`ifdef BAT_LOADER_VERIFY_READBACK_EN
    ST_VERIFY,
`endif
    ST_RELEASE
  } state_e;

  localparam logic MEM_RW_WRITE = 1'b1;
  localparam logic MEM_RW_READ  = 1'b0;

endpackage

// File: rtl/bat_addr_counter.sv
// -----------------------------------------------------------------------------
// bat_addr_counter
// Word counter for the loader. i_load clears the count and latches the target
// length; i_inc advances the count. o_tc_next flags that the next increment
// will reach the latched length.
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_load, i_len   clear count / capture length
//   i_inc           increment count
//   o_cnt           current count (ADDR_W+1 bits)
//   o_tc_next       (o_cnt + 1) == latched length
// -----------------------------------------------------------------------------
module bat_addr_counter #(
  parameter int ADDR_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic [ADDR_W:0] i_len,
  input  logic            i_inc,
  output logic [ADDR_W:0] o_cnt,
  output logic            o_tc_next
);

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] r_cnt;
  logic [ADDR_W:0] r_len;
  logic [ADDR_W:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + ONE;

  // NOTE: sequential state is only ever assigned with <= so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_len <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
      r_len <= i_len;
    end else if (i_inc) begin
      r_cnt <= w_cnt_inc;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_tc_next = (w_cnt_inc == r_len);

endmodule

// File: rtl/bat_debug_loader.sv
// -----------------------------------------------------------------------------
// bat_debug_loader
// Halt-mode program loader: on START holds the CPU in HALT, accepts LEN words
// over a valid/ready stream and writes them to RAM from BASE_ADDR upwards,
// then pulses CPU_RST_REQ/DONE and releases HALT.
// Optional build macro: BAT_LOADER_VERIFY_READBACK_EN (read back and compare
// each word after writing it; mismatch sets ERR and ends the load).
// Ports:
//   CLK, RST             clock, synchronous active-low reset
//   START, LEN, ABORT    load control (LEN sampled on START)
//   S_VALID/S_READY/S_DATA  word stream
//   HALT                 CPU halt; RAM owned by loader while high
//   MEM_ADDR/WDATA/RDATA/RW/EN  RAM master
//   CPU_RST_REQ, DONE    one-cycle pulses at release
//   BUSY, ERR, WORD_CNT  status
// -----------------------------------------------------------------------------
module bat_debug_loader
  import bat_loader_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W:0]   LEN,
  input  logic              ABORT,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [DATA_W-1:0] S_DATA,
  output logic              HALT,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              MEM_RW,
  output logic              MEM_EN,
  output logic              CPU_RST_REQ,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [ADDR_W:0]   WORD_CNT
);

  // One past the last addressable word; a load may end exactly here.
  localparam logic [ADDR_W+1:0] ADDR_SPACE = {2'b01, {ADDR_W{1'b0}}};

  state_e            r_state;
  state_e            w_next;
  logic              r_err;
  logic              r_done_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_start;
  logic              w_range_err;
  logic [ADDR_W+1:0] w_end;
  logic              w_hs;
  logic              w_cnt_inc;
  logic              w_tc;

  assign w_start     = (r_state == ST_IDLE) && START;
  assign w_end       = {2'b00, BASE_ADDR} + {1'b0, LEN};
  assign w_range_err = (w_end > ADDR_SPACE);
  // ABORT wins over a simultaneous handshake, so the word is not taken.
  assign w_hs        = (r_state == ST_ACCEPT) && S_VALID && !ABORT;

`ifdef BAT_LOADER_VERIFY_READBACK_EN
  logic w_vfy_bad;
  logic r_abort_pend;
  assign w_vfy_bad = (r_state == ST_VERIFY) && (MEM_RDATA != r_mem_wdata);
  assign w_cnt_inc = (r_state == ST_VERIFY) && !w_vfy_bad;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^MEM_RDATA;
  assign w_cnt_inc      = (r_state == ST_WRITE);
`endif

  bat_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_word_cnt (
    .i_clk     (CLK),
    .i_rst_n   (RST),
    .i_load    (w_start),
    .i_len     (LEN),
    .i_inc     (w_cnt_inc),
    .o_cnt     (WORD_CNT),
    .o_tc_next (w_tc)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_err       <= 1'b0;
      r_done_err  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef BAT_LOADER_VERIFY_READBACK_EN
      r_abort_pend <= 1'b0;
`endif
    end else begin
      r_state    <= w_next;
      r_done_err <= w_start && w_range_err;
      if (w_start) begin
        r_err <= w_range_err;
      end
`ifdef BAT_LOADER_VERIFY_READBACK_EN
      else if (w_vfy_bad) begin
        r_err <= 1'b1;
      end
      // An ABORT seen during WRITE is honoured once the read-back finishes.
      r_abort_pend <= (r_state == ST_WRITE) && ABORT;
`endif
      // Address and data are captured at the handshake and held afterwards.
      if (w_hs) begin
        r_mem_addr  <= BASE_ADDR + WORD_CNT[ADDR_W-1:0];
        r_mem_wdata <= S_DATA;
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case can infer a latch.
    w_next      = r_state;
    S_READY     = 1'b0;
    MEM_EN      = 1'b0;
    MEM_RW      = MEM_RW_READ;
    CPU_RST_REQ = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (START && !w_range_err) begin
          w_next = (LEN == '0) ? ST_RELEASE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        w_next = ABORT ? ST_RELEASE : ST_ACCEPT;
      end
      ST_ACCEPT: begin
        S_READY = 1'b1;
        if (ABORT) begin
          w_next = ST_RELEASE;
        end else if (S_VALID) begin
          w_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        MEM_EN = 1'b1;
        MEM_RW = MEM_RW_WRITE;
`ifdef BAT_LOADER_VERIFY_READBACK_EN
        w_next = ST_VERIFY;
      end
      ST_VERIFY: begin
        MEM_EN = 1'b1;
        w_next = (w_vfy_bad || w_tc || ABORT || r_abort_pend) ? ST_RELEASE : ST_ACCEPT;
      end
`else
        w_next = (w_tc || ABORT) ? ST_RELEASE : ST_ACCEPT;
      end
`endif
      ST_RELEASE: begin
        CPU_RST_REQ = 1'b1;
        w_next      = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign HALT      = (r_state != ST_IDLE);
  assign BUSY      = (r_state != ST_IDLE);
  assign DONE      = CPU_RST_REQ || r_done_err;
  assign ERR       = r_err;
  assign MEM_ADDR  = r_mem_addr;
  assign MEM_WDATA = r_mem_wdata;

endmodule

// File: tb/tb_bat_debug_loader.sv
// -----------------------------------------------------------------------------
// tb_bat_debug_loader
// Two loader instances: dut (BASE_ADDR=0x0010) for the main scenarios and
// dut_h (BASE_ADDR=0xFFFE) for the top-of-memory range cases. Expected writes
// are the words the bench itself handed over, placed at base+index.
// -----------------------------------------------------------------------------
module tb_bat_debug_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start_h;
  logic [16:0] len, len_h;
  logic        abort;
  logic        s_valid;
  logic [15:0] s_data;

  logic        s_ready, halt, mem_rw, mem_en, cpu_rst_req, busy, done, err;
  logic [15:0] mem_addr, mem_wdata;
  logic [16:0] word_cnt;
  logic        s_ready_h, halt_h, mem_rw_h, mem_en_h, cpu_rst_req_h, busy_h, done_h, err_h;
  logic [15:0] mem_addr_h, mem_wdata_h;
  logic [16:0] word_cnt_h;

  int n_cmp = 0;
  int n_fail = 0;

  // monitor state
  logic [15:0] wa0[$], wd0[$], wa1[$], wd1[$];
  int n_rr0, n_rr1, n_dn0, n_dn1, n_ht0, n_ht1, n_bad;
  // words the bench handed over in the current load
  logic [15:0] sent[$];

  always #5 clk = ~clk;

  bat_debug_loader #(.DATA_W(16), .ADDR_W(16), .BASE_ADDR(16'h0010)) dut (
    .CLK(clk), .RST(rst_n), .START(start), .LEN(len), .ABORT(abort),
    .S_VALID(s_valid), .S_READY(s_ready), .S_DATA(s_data), .HALT(halt),
    .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_wdata),
    .MEM_RW(mem_rw), .MEM_EN(mem_en), .CPU_RST_REQ(cpu_rst_req), .BUSY(busy),
    .DONE(done), .ERR(err), .WORD_CNT(word_cnt)
  );

  bat_debug_loader #(.DATA_W(16), .ADDR_W(16), .BASE_ADDR(16'hFFFE)) dut_h (
    .CLK(clk), .RST(rst_n), .START(start_h), .LEN(len_h), .ABORT(abort),
    .S_VALID(s_valid), .S_READY(s_ready_h), .S_DATA(s_data), .HALT(halt_h),
    .MEM_ADDR(mem_addr_h), .MEM_WDATA(mem_wdata_h), .MEM_RDATA(mem_wdata_h),
    .MEM_RW(mem_rw_h), .MEM_EN(mem_en_h), .CPU_RST_REQ(cpu_rst_req_h), .BUSY(busy_h),
    .DONE(done_h), .ERR(err_h), .WORD_CNT(word_cnt_h)
  );

  always @(negedge clk) begin
    if (mem_en && mem_rw) begin wa0.push_back(mem_addr); wd0.push_back(mem_wdata); end
    if (mem_en_h && mem_rw_h) begin wa1.push_back(mem_addr_h); wd1.push_back(mem_wdata_h); end
    if (cpu_rst_req) n_rr0++;
    if (cpu_rst_req_h) n_rr1++;
    if (done) n_dn0++;
    if (done_h) n_dn1++;
    if (halt) n_ht0++;
    if (halt_h) n_ht1++;
    if ((mem_en && !halt) || (mem_en_h && !halt_h)) n_bad++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
    n_rr0 = 0; n_rr1 = 0; n_dn0 = 0; n_dn1 = 0; n_ht0 = 0; n_ht1 = 0;
    sent.delete();
  endtask

  task automatic pulse_start(input bit hi, input logic [16:0] l);
    if (hi) begin start_h = 1'b1; len_h = l; end
    else    begin start   = 1'b1; len   = l; end
    tick();
    start = 1'b0; start_h = 1'b0;
  endtask

  // Idle the stream for gap cycles, then offer one word until it is taken.
  // Cycle 0 of the gap is never an accept cycle, so starvation is checked
  // from cycle 1 onward. With do_abort the word is offered together with ABORT.
  task automatic send_word(input bit hi, input logic [15:0] w, input int gap, input bit do_abort);
    bit got = 1'b0;
    s_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("starve_s_ready", hi ? s_ready_h : s_ready, 1);
        check("starve_mem_en", hi ? mem_en_h : mem_en, 0);
      end
      tick();
    end
    s_valid = 1'b1; s_data = w; abort = do_abort;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = hi ? s_ready_h : s_ready;
      tick();
    end
    s_valid = 1'b0; abort = 1'b0;
    check("handshake_taken", got, 1);
    if (got && !do_abort) sent.push_back(w);
  endtask

  task automatic wait_done(input bit hi);
    bit seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = hi ? done_h : done;
      if (!seen) tick();
    end
    check("done_seen", seen, 1);
  endtask

  // Called at the negedge of the DONE cycle; n is the expected word count.
  task automatic check_release(input bit hi, input int n, input logic [15:0] base);
    check("rel_cpu_rst_req", hi ? cpu_rst_req_h : cpu_rst_req, 1);
    check("rel_halt", hi ? halt_h : halt, 1);
    tick();
    @(negedge clk);
    check("post_halt", hi ? halt_h : halt, 0);
    check("post_busy", hi ? busy_h : busy, 0);
    check("post_done", hi ? done_h : done, 0);
    check("post_word_cnt", hi ? word_cnt_h : word_cnt, n);
    check("post_err", hi ? err_h : err, 0);
    check("rst_req_pulses", hi ? n_rr1 : n_rr0, 1);
    check("done_pulses", hi ? n_dn1 : n_dn0, 1);
    check("n_writes", hi ? wa1.size() : wa0.size(), n);
    check("n_sent", sent.size(), n);
    for (int i = 0; i < n && i < sent.size(); i++) begin
      logic [15:0] ea;
      ea = base + 16'(i);
      check("wr_addr", hi ? wa1[i] : wa0[i], ea);
      check("wr_data", hi ? wd1[i] : wd0[i], sent[i]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; start_h = 1'b0; len = '0; len_h = '0;
    abort = 1'b0; s_valid = 1'b0; s_data = '0; n_bad = 0;
    clear_mon();
    repeat (3) tick();

    // ---- reset state
    @(negedge clk);
    check("rst_halt", halt, 0);         check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);     check("rst_mem_rw", mem_rw, 0);
    check("rst_word_cnt", word_cnt, 0); check("rst_err", err, 0);
    check("rst_done", done, 0);         check("rst_cpu_rst_req", cpu_rst_req, 0);
    check("rst_s_ready", s_ready, 0);   check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_h_halt", halt_h, 0);     check("rst_h_err", err_h, 0);
    rst_n = 1'b1;
    tick();

    // ---- basic load: 3 words at 0x0010, stream always valid
    clear_mon();
    pulse_start(0, 17'd3);
    @(negedge clk);
    check("settle_halt", halt, 1);
    check("settle_s_ready", s_ready, 0);
    check("settle_mem_en", mem_en, 0);
    send_word(0, 16'hA001, 0, 0);
    send_word(0, 16'hA002, 0, 0);
    send_word(0, 16'hA003, 0, 0);
    wait_done(0);
    check_release(0, 3, 16'h0010);
    check("basic_halt_cycles", n_ht0, 8);
    check("hold_mem_addr", mem_addr, 16'h0012);
    check("hold_mem_wdata", mem_wdata, 16'hA003);

    // ---- backpressure, plus a START while busy that must be ignored
    clear_mon();
    pulse_start(0, 17'd2);
    send_word(0, 16'hB0B0, 0, 0);
    start = 1'b1; len = 17'd7;
    tick();
    start = 1'b0;
    send_word(0, 16'hB1B1, 5, 0);
    wait_done(0);
    check_release(0, 2, 16'h0010);

    // ---- range error: 0xFFFE + 3 runs past the top of memory
    clear_mon();
    pulse_start(1, 17'd3);
    @(negedge clk);
    check("range_done", done_h, 1);
    check("range_err", err_h, 1);
    check("range_halt", halt_h, 0);
    check("range_busy", busy_h, 0);
    repeat (4) tick();
    @(negedge clk);
    check("range_done_gone", done_h, 0);
    check("range_err_sticky", err_h, 1);
    check("range_halt_cycles", n_ht1, 0);
    check("range_writes", wa1.size(), 0);
    check("range_rst_req", n_rr1, 0);

    // ---- range boundary: 0xFFFE + 2 exactly fills memory, clears ERR
    tick();
    clear_mon();
    pulse_start(1, 17'd2);
    send_word(1, 16'hC001, 0, 0);
    send_word(1, 16'hC002, 1, 0);
    wait_done(1);
    check_release(1, 2, 16'hFFFE);

    // ---- LEN=0: straight to release
    tick();
    clear_mon();
    pulse_start(0, 17'd0);
    @(negedge clk);
    check("len0_done", done, 1);
    check("len0_cpu_rst_req", cpu_rst_req, 1);
    check("len0_s_ready", s_ready, 0);
    check("len0_mem_en", mem_en, 0);
    tick();
    @(negedge clk);
    check("len0_halt", halt, 0);
    check("len0_busy", busy, 0);
    check("len0_word_cnt", word_cnt, 0);
    check("len0_writes", wa0.size(), 0);

    // ---- ABORT after 2 of 4 words, offered together with a valid word
    tick();
    clear_mon();
    pulse_start(0, 17'd4);
    send_word(0, 16'hD001, 0, 0);
    send_word(0, 16'hD002, 0, 0);
    send_word(0, 16'hDEAD, 1, 1);
    wait_done(0);
    check_release(0, 2, 16'h0010);

    // ---- reset during WRITE of word 1
    tick();
    clear_mon();
    pulse_start(0, 17'd3);
    send_word(0, 16'hE000, 0, 0);
    send_word(0, 16'hE001, 0, 0);
    @(negedge clk);
    check("mid_in_write", {mem_en, mem_rw, word_cnt[15:0]}, {2'b11, 16'd1});
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("mid_rst_halt", halt, 0);
    check("mid_rst_mem_en", mem_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cpu_rst_req", cpu_rst_req, 0);
    check("mid_rst_word_cnt", word_cnt, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("mid_rst_no_req", n_rr0, 0);

    // ---- randomized loads, some aborted, with random stream gaps
    for (int t = 0; t < 10; t++) begin
      int l, ab;
      l  = $urandom_range(1, 6);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, l - 1) : l;
      clear_mon();
      pulse_start(0, 17'(l));
      for (int i = 0; i < ab; i++) send_word(0, 16'($urandom), $urandom_range(0, 3), 0);
      if (ab < l) send_word(0, 16'($urandom), $urandom_range(1, 3), 1);
      wait_done(0);
      check_release(0, ab, 16'h0010);
      tick();
    end

    check("mem_en_without_halt", n_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
